// File: rtl/mult_share_arbiter.sv
// Round-robin sequencer sharing one sequential signed 4x4 multiplier between N requesters.
// Latches the winner's operands, pulses start, waits for done or timeout, then acks the winner.
module mult_share_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic [4*N-1:0]   mplier_in_i,
    input  logic [4*N-1:0]   mcand_in_i,
    output logic [N-1:0]     gnt_o,
    output logic [N-1:0]     ack_o,
    output logic [8:0]       prod_out_o,
    output logic             err_o,
    output logic             busy_o,
    output logic             mul_st_o,
    output logic [3:0]       mul_mplier_o,
    output logic [3:0]       mul_mcand_o,
    input  logic [8:0]       mul_prod_i,
    input  logic             mul_done_i
);

    localparam int unsigned PW = $clog2(N);
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win_q, win_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [8:0]      prod_q, prod_d;
    logic            err_q, err_d;
    logic [3:0]      mplier_q, mplier_d;
    logic [3:0]      mcand_q, mcand_d;

    logic            found;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   idx;
    int unsigned     k;

    // First pending requester scanning ptr, ptr+1, .. ptr-1 (mod N).
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        k     = 0;
        for (int i = 0; i < int'(N); i++) begin
            k   = (int'(ptr_q) + i) % N;
            idx = PW'(k);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        timer_d  = timer_q;
        prod_d   = prod_q;
        err_d    = err_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    win_d       = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    mplier_d    = mplier_in_i[{pick, 2'b00} +: 4];
                    mcand_d     = mcand_in_i[{pick, 2'b00} +: 4];
                    state_d     = StStart;
                end
            end
            StStart: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                timer_d = timer_q + 1'b1;
                // done wins over a timeout in the same cycle
                if (mul_done_i) begin
                    prod_d  = mul_prod_i;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            timer_q  <= '0;
            prod_q   <= '0;
            err_q    <= 1'b0;
            mplier_q <= '0;
            mcand_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            timer_q  <= timer_d;
            prod_q   <= prod_d;
            err_q    <= err_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign ack_o        = (state_q == StResp) ? gnt_q : '0;
    assign prod_out_o   = prod_q;
    assign err_o        = err_q;
    assign busy_o       = (state_q != StIdle);
    // Holding St during reset aborts any multiplication in flight.
    assign mul_st_o     = rst_i | (state_q == StStart);
    assign mul_mplier_o = mplier_q;
    assign mul_mcand_o  = mcand_q;

endmodule
